write_back: RTL and testbench
=============================

WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL provide these ports, one per line as name, direction, width, meaning:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- commit_i  in  1  instruction from memory stage valid this cycle.
- icode_i  in  4  instruction code: NOP 0, HALT 1, RRMOVL 2, IRMOVL 3, RMMOVL 4, MRMOVL 5, ALU 6, JXX 7, CALL 8, RET 9, PUSHL A, POPL B.
- rA_i, rB_i  in  4 each  register specifiers; F means none.
- cnd_i  in  1  condition result from execute stage.
- valE_i  in  64  ALU result.
- valM_i  in  64  memory stage read data.
- imem_error_i  in  1  fetch address error.
- dmem_error_i  in  1  memory stage error.
- srcA_i, srcB_i  in  4 each  decode read addresses.
- valA_o, valB_o  out  64 each  decode read data.
- stat_o  out  3  status: AOK 1, HLT 2, ADR 3, INS 4.
- halted_o  out  1  processor stopped (stat_o != AOK).
- retired_o  out  64  count of committed instructions.

Function
REQ-003 The block SHALL hold 15 registers of 64 bits, indices 0..14; index 4 is %rsp.
REQ-004 valA_o/valB_o SHALL be combinational reads of the array. An index of F SHALL return 0. There is no same-cycle write bypass.
REQ-005 The E-port destination dstE SHALL be:
- rB_i for IRMOVL and ALU.
- rB_i for RRMOVL when cnd_i=1, else F.
- 4 for PUSHL, POPL, CALL and RET.
- F otherwise.
REQ-006 The M-port destination dstM SHALL be rA_i for MRMOVL and POPL, else F.
REQ-007 The instruction status SHALL be computed with this priority:
- ADR if imem_error_i or dmem_error_i.
- else INS if icode_i > B.
- else HLT if icode_i = HALT.
- else AOK.
REQ-008 A commit SHALL occur when commit_i=1 and the stored state is AOK.
REQ-009 On a commit with instruction status AOK, the rising edge SHALL write valE_i to dstE and valM_i to dstM. A destination of F SHALL not be written.
REQ-010 If dstE equals dstM and neither is F (e.g. POPL %rsp), valM_i SHALL be written and valE_i discarded.
REQ-011 On a commit with instruction status not AOK, no register SHALL be written.
REQ-012 The state machine SHALL have states RUN (stat_o=AOK) and STOP (stat_o latched to HLT/ADR/INS).
- RUN goes to STOP on a commit whose status is not AOK, latching that status.
- STOP is sticky until reset.
REQ-013 In STOP, commit_i SHALL be ignored: no writes, no counting, stat_o unchanged.
REQ-014 retired_o SHALL increment by 1 on every commit, including the one entering STOP. It SHALL wrap from 2^64-1 to 0.
REQ-015 Writes and state changes SHALL take effect at the edge. Reads in the following cycle SHALL return the new data, giving a 1-cycle write-to-read latency.
REQ-016 When commit_i=0, the block SHALL hold all state.

Reset
REQ-017 On rst_i=1 at a rising edge, the block SHALL clear all 15 registers to 0, set stat_o=AOK and halted_o=0, and set retired_o=0.
REQ-018 Reset SHALL take priority over a simultaneous commit; that commit is dropped.
REQ-019 Reset asserted while in STOP SHALL return the block to RUN.

Verification
REQ-020 A bench SHALL cover at least these directed scenarios:
- IRMOVL rB=2, valE=0x1122334455667788, commit 1 cycle -> next cycle srcA=2 gives valA_o=0x1122334455667788; retired_o=1.
- RRMOVL rB=3, valE=0xAA: with cnd_i=0 -> reg3 stays 0; with cnd_i=1 -> reg3=0xAA.
- POPL rA=4, valE=0x108, valM=0xDEADBEEFCAFEBABE -> reg4=0xDEADBEEFCAFEBABE (M wins); POPL rA=1, valE=0x110, valM=0x5 -> reg1=0x5 and reg4=0x110.
- MRMOVL rA=6, dmem_error_i=1, valM=0x77 -> reg6 unchanged, stat_o=3, halted_o=1, retired_o increments. A following IRMOVL rB=6 is ignored and retired_o is unchanged.
- HALT commit -> stat_o=2. icode=0xE from reset -> stat_o=4. The error-priority case: imem_error_i=1 with icode=1 -> stat_o=3.
- Reset in STOP with a simultaneous IRMOVL commit -> all registers 0, stat_o=1, retired_o=0. Reading srcA=F -> valA_o=0.

Source files
------------

// File: rtl/write_back_if.sv
// Write-back stage signal bundle. The master side is the pipeline driving commits
// and decode reads; the slave side is the register file / status block.
interface write_back_if;
  logic        commit_i;
  logic [3:0]  icode_i;
  logic [3:0]  rA_i;
  logic [3:0]  rB_i;
  logic        cnd_i;
  logic [63:0] valE_i;
  logic [63:0] valM_i;
  logic        imem_error_i;
  logic        dmem_error_i;
  logic [3:0]  srcA_i;
  logic [3:0]  srcB_i;
  logic [63:0] valA_o;
  logic [63:0] valB_o;
  logic [2:0]  stat_o;
  logic        halted_o;
  logic [63:0] retired_o;

  modport master (
    output commit_i, icode_i, rA_i, rB_i, cnd_i, valE_i, valM_i,
           imem_error_i, dmem_error_i, srcA_i, srcB_i,
    input  valA_o, valB_o, stat_o, halted_o, retired_o
  );

  modport slave (
    input  commit_i, icode_i, rA_i, rB_i, cnd_i, valE_i, valM_i,
           imem_error_i, dmem_error_i, srcA_i, srcB_i,
    output valA_o, valB_o, stat_o, halted_o, retired_o
  );
endinterface

// File: rtl/write_back.sv
// Y86-64 write-back stage: 15-entry register file, processor status machine and
// retired-instruction counter.
module write_back (
  input logic         clk_i,
  input logic         rst_i,
  write_back_if.slave wb
);

  localparam logic [3:0] I_HALT   = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_ALU    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [3:0] R_RSP    = 4'h4;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic {RUN, STOP} stateT;

  stateT       state, nextState;
  logic [2:0]  statLatched, nextStatLatched;
  logic [63:0] regFile [0:14];
  logic [63:0] retiredCount;
  logic [3:0]  dstE, dstM;
  logic [2:0]  instrStat;
  logic        commitEn;
  logic        writeEn;

  always_comb begin
    dstE = R_NONE;
    dstM = R_NONE;
    case (wb.icode_i)
      I_IRMOVL, I_ALU:                 dstE = wb.rB_i;
      I_RRMOVL:                        dstE = wb.cnd_i ? wb.rB_i : R_NONE;
      I_PUSHL, I_CALL, I_RET:          dstE = R_RSP;
      I_POPL: begin
        dstE = R_RSP;
        dstM = wb.rA_i;
      end
      I_MRMOVL:                        dstM = wb.rA_i;
      default: ;
    endcase
  end

  // Address faults outrank an illegal opcode, which outranks a clean halt.
  always_comb begin
    instrStat = S_AOK;
    if (wb.imem_error_i || wb.dmem_error_i)
      instrStat = S_ADR;
    else if (wb.icode_i > I_POPL)
      instrStat = S_INS;
    else if (wb.icode_i == I_HALT)
      instrStat = S_HLT;
  end

  assign commitEn = wb.commit_i && (state == RUN);
  assign writeEn  = commitEn && (instrStat == S_AOK);

  always_comb begin
    nextState       = state;
    nextStatLatched = statLatched;
    if (commitEn && instrStat != S_AOK) begin
      nextState       = STOP;
      nextStatLatched = instrStat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= RUN;
      statLatched  <= S_AOK;
      retiredCount <= '0;
    end else begin
      state       <= nextState;
      statLatched <= nextStatLatched;
      if (commitEn)
        retiredCount <= retiredCount + 64'd1;
    end
  end

  // The M port is checked first so that POPL %rsp keeps the popped value.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 15; i++) begin
      if (rst_i)
        regFile[i] <= '0;
      else if (writeEn && dstM == 4'(i))
        regFile[i] <= wb.valM_i;
      else if (writeEn && dstE == 4'(i))
        regFile[i] <= wb.valE_i;
    end
  end

  assign wb.valA_o    = (wb.srcA_i == R_NONE) ? 64'd0 : regFile[wb.srcA_i];
  assign wb.valB_o    = (wb.srcB_i == R_NONE) ? 64'd0 : regFile[wb.srcB_i];
  assign wb.stat_o    = (state == RUN) ? S_AOK : statLatched;
  assign wb.halted_o  = (state != RUN);
  assign wb.retired_o = retiredCount;

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: stimulus queues expected observations, a
// negedge monitor pops and compares them against the live outputs.
module tb_write_back;

  localparam int K_VALA    = 0;
  localparam int K_VALB    = 1;
  localparam int K_STAT    = 2;
  localparam int K_HALTED  = 3;
  localparam int K_RETIRED = 4;

  typedef struct {
    int          kind;
    logic [63:0] expVal;
    string       name;
  } CheckItem;

  logic clk;
  logic rst;
  logic probe;
  int   compared;
  int   mismatched;
  CheckItem expectQ[$];

  write_back_if wbIf ();

  write_back dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: whenever a probe is presented, every queued expectation is checked.
  always @(negedge clk) begin
    if (probe) begin
      while (expectQ.size() > 0) begin
        CheckItem item;
        logic [63:0] actual;
        item = expectQ.pop_front();
        case (item.kind)
          K_VALA:    actual = wbIf.valA_o;
          K_VALB:    actual = wbIf.valB_o;
          K_STAT:    actual = {61'd0, wbIf.stat_o};
          K_HALTED:  actual = {63'd0, wbIf.halted_o};
          default:   actual = wbIf.retired_o;
        endcase
        compared++;
        if (actual !== item.expVal) begin
          mismatched++;
          $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", item.name, actual, item.expVal);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] rA,
                               input logic [3:0] rB, input logic cnd,
                               input logic [63:0] valE, input logic [63:0] valM,
                               input logic imemErr, input logic dmemErr,
                               input logic doCommit, input logic doReset);
    wbIf.icode_i      = icode;
    wbIf.rA_i         = rA;
    wbIf.rB_i         = rB;
    wbIf.cnd_i        = cnd;
    wbIf.valE_i       = valE;
    wbIf.valM_i       = valM;
    wbIf.imem_error_i = imemErr;
    wbIf.dmem_error_i = dmemErr;
    wbIf.commit_i     = doCommit;
    rst               = doReset;
    @(posedge clk);
    #1;
    wbIf.commit_i     = 1'b0;
    wbIf.imem_error_i = 1'b0;
    wbIf.dmem_error_i = 1'b0;
    rst               = 1'b0;
  endtask

  task automatic checkOutput(input int kind, input logic [3:0] addr,
                             input logic [63:0] expVal, input string name);
    CheckItem item;
    if (kind == K_VALA) wbIf.srcA_i = addr;
    if (kind == K_VALB) wbIf.srcB_i = addr;
    item.kind   = kind;
    item.expVal = expVal;
    item.name   = name;
    expectQ.push_back(item);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic checkStatus(input logic [2:0] stat, input logic halted,
                             input logic [63:0] retired, input string tag);
    checkOutput(K_STAT,    4'hF, {61'd0, stat},   {tag, "_stat"});
    checkOutput(K_HALTED,  4'hF, {63'd0, halted}, {tag, "_halted"});
    checkOutput(K_RETIRED, 4'hF, retired,         {tag, "_retired"});
  endtask

  task automatic doReset();
    applyStimulus(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    probe      = 1'b0;
    rst        = 1'b1;
    wbIf.commit_i = 1'b0;
    wbIf.icode_i  = 4'h0;
    wbIf.rA_i     = 4'hF;
    wbIf.rB_i     = 4'hF;
    wbIf.cnd_i    = 1'b0;
    wbIf.valE_i   = '0;
    wbIf.valM_i   = '0;
    wbIf.imem_error_i = 1'b0;
    wbIf.dmem_error_i = 1'b0;
    wbIf.srcA_i   = 4'hF;
    wbIf.srcB_i   = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkStatus(3'd1, 1'b0, 64'd0, "reset");
    checkOutput(K_VALA, 4'd0, 64'd0, "reset_reg0");

    // IRMOVL into %rdx, visible on the next cycle
    applyStimulus(4'h3, 4'hF, 4'd2, 1'b0, 64'h1122334455667788, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(K_VALA, 4'd2, 64'h1122334455667788, "irmovl_reg2");
    checkOutput(K_RETIRED, 4'hF, 64'd1, "irmovl_retired");

    // Idle cycle with a pending-looking instruction must not write
    applyStimulus(4'h3, 4'hF, 4'd2, 1'b0, 64'h99, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(K_VALB, 4'd2, 64'h1122334455667788, "hold_reg2");
    checkOutput(K_RETIRED, 4'hF, 64'd1, "hold_retired");

    // Conditional move, not taken then taken
    applyStimulus(4'h2, 4'd0, 4'd3, 1'b0, 64'hAA, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(K_VALA, 4'd3, 64'd0, "cmov_nt_reg3");
    applyStimulus(4'h2, 4'd0, 4'd3, 1'b1, 64'hAA, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(K_VALA, 4'd3, 64'hAA, "cmov_t_reg3");
    checkOutput(K_RETIRED, 4'hF, 64'd3, "cmov_retired");

    // POPL %rsp: memory value wins over the stack-pointer update
    applyStimulus(4'hB, 4'd4, 4'hF, 1'b0, 64'h108, 64'hDEADBEEFCAFEBABE, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(K_VALA, 4'd4, 64'hDEADBEEFCAFEBABE, "popl_rsp_reg4");
    applyStimulus(4'hB, 4'd1, 4'hF, 1'b0, 64'h110, 64'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(K_VALA, 4'd1, 64'h5, "popl_reg1");
    checkOutput(K_VALB, 4'd4, 64'h110, "popl_reg4");

    // CALL updates %rsp; ALU writes rB; IRMOVL to F writes nothing
    applyStimulus(4'h8, 4'hF, 4'hF, 1'b0, 64'h200, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(K_VALA, 4'd4, 64'h200, "call_reg4");
    applyStimulus(4'h6, 4'd7, 4'd7, 1'b0, 64'h1234, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(K_VALB, 4'd7, 64'h1234, "alu_reg7");
    applyStimulus(4'h3, 4'hF, 4'hF, 1'b0, 64'h55, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(K_VALA, 4'd0, 64'd0, "nodst_reg0");
    checkOutput(K_VALA, 4'd14, 64'd0, "nodst_reg14");
    checkStatus(3'd1, 1'b0, 64'd8, "run");

    // Data-memory fault stops the machine without writing
    applyStimulus(4'h5, 4'd6, 4'hF, 1'b0, 64'h0, 64'h77, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput(K_VALA, 4'd6, 64'd0, "adr_reg6");
    checkStatus(3'd3, 1'b1, 64'd9, "adr");
    applyStimulus(4'h3, 4'hF, 4'd6, 1'b0, 64'h1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(K_VALA, 4'd6, 64'd0, "stop_reg6");
    checkStatus(3'd3, 1'b1, 64'd9, "stop");

    // Reset in STOP beats a simultaneous commit
    applyStimulus(4'h3, 4'hF, 4'd5, 1'b0, 64'h9, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput(K_VALA, 4'd5, 64'd0, "rst_reg5");
    checkOutput(K_VALA, 4'd2, 64'd0, "rst_reg2");
    checkOutput(K_VALB, 4'd4, 64'd0, "rst_reg4");
    checkOutput(K_VALA, 4'hF, 64'd0, "rst_none");
    checkStatus(3'd1, 1'b0, 64'd0, "rst");

    // HALT, illegal opcode, and fetch error outranking HALT
    applyStimulus(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkStatus(3'd2, 1'b1, 64'd1, "halt");
    doReset();
    applyStimulus(4'hE, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkStatus(3'd4, 1'b1, 64'd1, "ins");
    doReset();
    applyStimulus(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkStatus(3'd3, 1'b1, 64'd1, "imem");

    for (int i = 0; i < 10 && expectQ.size() > 0; i++) @(posedge clk);
    if (expectQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expectQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
